// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared types and helpers for the VGA mode scheduler.
//   show_mode_t   : picture source selected for the VGA datapath
//   sched_state_t : scheduler FSM states
//   next_mode()   : rotation order TIME -> WAVEFORM -> SPECTRUM -> TIME
//   cnt_width()   : width of a saturating counter able to hold max_val
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        RST_IMG  = 2'd0,
        TIME     = 2'd1,
        WAVEFORM = 2'd2,
        SPECTRUM = 2'd3
    } show_mode_t;

    typedef enum logic [1:0] {
        SPLASH = 2'd0,
        AUTO   = 2'd1,
        MANUAL = 2'd2
    } sched_state_t;

    // RST_IMG is only left, never re-entered, so it advances to TIME.
    function automatic show_mode_t next_mode(input show_mode_t m);
        case (m)
            TIME:     next_mode = WAVEFORM;
            WAVEFORM: next_mode = SPECTRUM;
            default:  next_mode = TIME;
        endcase
    endfunction

    // At least one bit so a zero-valued limit still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        cnt_width = (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Turns a raw pushbutton level into a single-cycle request pulse.
// Only instantiated when VGA_MODE_SCHED_DEBOUNCE_EN is defined.
//   clk   : pixel clock
//   rst   : asynchronous active-high reset
//   raw   : raw active-high button level (asynchronous to clk)
//   pulse : one-cycle pulse on each debounced press
// ---------------------------------------------------------------------------
module btn_debounce
    import vga_pkg::*;
#(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((DEB_CYCLES < 1) ? 0 : DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          filt;
    logic [CW-1:0] cnt;

    // The counter restarts whenever the synchronised level matches the
    // filtered one, so only an unbroken run of differing samples flips it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            filt   <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            pulse  <= 1'b0;
            if (sync_b == filt) begin
                cnt <= '0;
            end else if (cnt >= LAST) begin
                filt  <= sync_b;
                cnt   <= '0;
                pulse <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_mode_sched.sv
// ---------------------------------------------------------------------------
// vga_mode_sched
// Frame-synchronous scheduler choosing the VGA picture source. Requests from
// the "next" button, audio activity and the auto-rotate dwell timer are
// latched during a frame and applied only on the cycle after a vsync
// assertion is detected, so a frame never tears.
//
// Ports:
//   clk_i          : pixel clock (25 MHz)
//   rst_i          : asynchronous active-high reset
//   vs_i           : vsync from the timing generator, active-low
//   btn_next_i     : "next mode" single-cycle pulse
//                    (raw button level when VGA_MODE_SCHED_DEBOUNCE_EN)
//   auto_en_i      : auto-rotate enable level
//   audio_active_i : audio-present level
//   show_mode_o    : 0 RST_IMG, 1 TIME, 2 WAVEFORM, 3 SPECTRUM
//   mode_changed_o : one-cycle pulse in the first cycle of a new mode value
//   frame_tick_o   : one-cycle pulse per detected vsync assertion
//   dbg_state      : current scheduler state (sched_state_t encoding)
//
// Build option: define VGA_MODE_SCHED_DEBOUNCE_EN to debounce a raw button.
// ---------------------------------------------------------------------------
module vga_mode_sched
    import vga_pkg::*;
#(
    parameter int SPLASH_FRAMES = 60,
    parameter int DWELL_FRAMES  = 600,
    parameter int HOLD_FRAMES   = 300,
    parameter int DEB_CYCLES    = 250000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vs_i,
    input  logic       btn_next_i,
    input  logic       auto_en_i,
    input  logic       audio_active_i,
    output logic [1:0] show_mode_o,
    output logic       mode_changed_o,
    output logic       frame_tick_o,
    output logic [1:0] dbg_state
);

    localparam int SW = cnt_width(SPLASH_FRAMES);
    localparam int DW = cnt_width(DWELL_FRAMES);
    localparam int HW = cnt_width(HOLD_FRAMES);

    localparam logic [SW-1:0] SPLASH_MAX = SW'(SPLASH_FRAMES);
    localparam logic [DW-1:0] DWELL_MAX  = DW'(DWELL_FRAMES);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);

    sched_state_t  state, state_nxt;
    show_mode_t    mode, mode_nxt;
    logic [SW-1:0] splash_cnt, splash_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;

    logic vs_q;
    logic aud_q;
    logic btn_pend;
    logic aud_pend;
    logic btn_req;
    logic aud_rise;
    logic btn_now;
    logic aud_now;
    logic splash_done;
    logic dwell_done;
    logic hold_done;

`ifdef VGA_MODE_SCHED_DEBOUNCE_EN
    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk_i),
        .rst   (rst_i),
        .raw   (btn_next_i),
        .pulse (btn_req)
    );
`else
    assign btn_req = btn_next_i;
`endif

    assign aud_rise = audio_active_i & ~aud_q;

    // Requests arriving on the tick cycle itself are honoured at that tick.
    assign btn_now = btn_pend | btn_req;
    assign aud_now = aud_pend | aud_rise;

    // "Reached N" means this tick would make the count equal N; a zero
    // limit fires on every tick.
    assign splash_done = (SPLASH_FRAMES == 0) || (splash_cnt >= SPLASH_MAX - 1'b1);
    assign dwell_done  = (DWELL_FRAMES == 0)  || (dwell_cnt  >= DWELL_MAX - 1'b1);
    assign hold_done   = (HOLD_FRAMES == 0)   || (hold_cnt   >= HOLD_MAX - 1'b1);

    // Next-state decision, consumed only on the tick cycle.
    // Priority: button > audio wake > dwell expiry; one change per tick.
    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode;
        splash_nxt = splash_cnt;
        dwell_nxt  = dwell_cnt;
        hold_nxt   = hold_cnt;
        case (state)
            SPLASH: begin
                if (btn_now) begin
                    mode_nxt  = TIME;
                    state_nxt = MANUAL;
                    hold_nxt  = '0;
                end else if (splash_done) begin
                    mode_nxt  = TIME;
                    state_nxt = AUTO;
                    dwell_nxt = '0;
                end else begin
                    splash_nxt = splash_cnt + 1'b1;
                end
            end
            AUTO: begin
                if (btn_now) begin
                    mode_nxt  = next_mode(mode);
                    state_nxt = MANUAL;
                    hold_nxt  = '0;
                end else if (aud_now && (mode == TIME)) begin
                    mode_nxt  = WAVEFORM;
                    dwell_nxt = '0;
                end else if (auto_en_i) begin
                    if (dwell_done) begin
                        mode_nxt  = next_mode(mode);
                        dwell_nxt = '0;
                    end else begin
                        dwell_nxt = dwell_cnt + 1'b1;
                    end
                end
            end
            MANUAL: begin
                if (btn_now) begin
                    mode_nxt = next_mode(mode);
                    hold_nxt = '0;
                end else if (hold_done) begin
                    if (auto_en_i) begin
                        state_nxt = AUTO;
                        dwell_nxt = '0;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = HOLD_MAX;
                    end
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = SPLASH;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_q           <= 1'b0;
            aud_q          <= 1'b0;
            frame_tick_o   <= 1'b0;
            mode_changed_o <= 1'b0;
            btn_pend       <= 1'b0;
            aud_pend       <= 1'b0;
            state          <= SPLASH;
            mode           <= RST_IMG;
            splash_cnt     <= '0;
            dwell_cnt      <= '0;
            hold_cnt       <= '0;
        end else begin
            vs_q           <= vs_i;
            aud_q          <= audio_active_i;
            frame_tick_o   <= vs_q & ~vs_i;
            mode_changed_o <= 1'b0;
            if (frame_tick_o) begin
                state          <= state_nxt;
                mode           <= mode_nxt;
                splash_cnt     <= splash_nxt;
                dwell_cnt      <= dwell_nxt;
                hold_cnt       <= hold_nxt;
                mode_changed_o <= (mode_nxt != mode);
                // Every tick consumes the latched requests; a losing
                // audio request is simply dropped.
                btn_pend       <= 1'b0;
                aud_pend       <= 1'b0;
            end else begin
                if (btn_req) btn_pend <= 1'b1;
                if (aud_rise) aud_pend <= 1'b1;
            end
        end
    end

    assign show_mode_o = mode;
    assign dbg_state   = state;

endmodule

// File: tb/tb_vga_mode_sched.sv
// ---------------------------------------------------------------------------
// tb_vga_mode_sched
// Directed bench for vga_mode_sched with SPLASH=2, DWELL=3, HOLD=4 and a
// 20-cycle vsync period (low for two sampled edges per frame).
// ---------------------------------------------------------------------------
module tb_vga_mode_sched;

    localparam logic [1:0] ST_SPLASH = 2'd0;
    localparam logic [1:0] ST_AUTO   = 2'd1;
    localparam logic [1:0] ST_MANUAL = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs;
    logic       btn;
    logic       auto_en;
    logic       audio;
    logic [1:0] show_mode;
    logic       mode_changed;
    logic       frame_tick;
    logic [1:0] dbg_state;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_mode;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vga_mode_sched #(
        .SPLASH_FRAMES (2),
        .DWELL_FRAMES  (3),
        .HOLD_FRAMES   (4),
        .DEB_CYCLES    (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .vs_i           (vs),
        .btn_next_i     (btn),
        .auto_en_i      (auto_en),
        .audio_active_i (audio),
        .show_mode_o    (show_mode),
        .mode_changed_o (mode_changed),
        .frame_tick_o   (frame_tick),
        .dbg_state      (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_btn();
        btn = 1'b1;
        step();
        btn = 1'b0;
        step();
    endtask

    // One frame: high period, then vs low for two edges. Edge A samples vs
    // low and raises the tick; edge B applies the mode update.
    task automatic tick_frame(input string tag, input logic [1:0] m);
        vs = 1'b1;
        repeat (17) step();
        vs = 1'b0;
        step();
        chk({tag, ":tick"}, {3'b0, frame_tick}, 4'd1);
        chk({tag, ":pre"}, {2'b0, show_mode}, {2'b0, exp_mode});
        step();
        chk({tag, ":mode"}, {2'b0, show_mode}, {2'b0, m});
        chk({tag, ":chg"}, {3'b0, mode_changed}, {3'b0, (m != exp_mode)});
        chk({tag, ":tick_end"}, {3'b0, frame_tick}, 4'd0);
        vs = 1'b1;
        step();
        chk({tag, ":chg_end"}, {3'b0, mode_changed}, 4'd0);
        exp_mode = m;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b1;
        vs       = 1'b0;
        btn      = 1'b0;
        auto_en  = 1'b0;
        audio    = 1'b0;
        exp_mode = 2'd0;
        repeat (3) step();
        chk("rst_mode", {2'b0, show_mode}, 4'd0);
        chk("rst_chg", {3'b0, mode_changed}, 4'd0);
        chk("rst_tick", {3'b0, frame_tick}, 4'd0);
        chk("rst_state", {2'b0, dbg_state}, {2'b0, ST_SPLASH});

        // Release with vs low: no tick until a high-to-low is seen.
        rst = 1'b0;
        repeat (5) begin
            step();
            chk("no_early_tick", {3'b0, frame_tick}, 4'd0);
        end
        tick_frame("splash1", 2'd0);
        chk("splash1_state", {2'b0, dbg_state}, {2'b0, ST_SPLASH});
        tick_frame("splash2", 2'd1);
        chk("splash2_state", {2'b0, dbg_state}, {2'b0, ST_AUTO});
        tick_frame("frozen_a", 2'd1);
        tick_frame("frozen_b", 2'd1);

        // Auto-rotate.
        auto_en = 1'b1;
        tick_frame("rot1", 2'd1);
        tick_frame("rot2", 2'd1);
        tick_frame("rot3", 2'd2);
        tick_frame("rot4", 2'd2);
        tick_frame("rot5", 2'd2);
        tick_frame("rot6", 2'd3);
        tick_frame("rot7", 2'd3);
        tick_frame("rot8", 2'd3);
        tick_frame("rot9", 2'd1);
        tick_frame("rot10", 2'd1);

        // Freeze for 5 ticks; dwell resumes from 1, not 0.
        auto_en = 1'b0;
        repeat (5) tick_frame("freeze", 2'd1);
        auto_en = 1'b1;
        tick_frame("resume1", 2'd1);
        tick_frame("resume2", 2'd2);

        // Rotate back to TIME.
        tick_frame("back1", 2'd2);
        tick_frame("back2", 2'd2);
        tick_frame("back3", 2'd3);
        tick_frame("back4", 2'd3);
        tick_frame("back5", 2'd3);
        tick_frame("back6", 2'd1);

        // Three pulses in one frame collapse into one advance.
        pulse_btn();
        pulse_btn();
        pulse_btn();
        tick_frame("btn3", 2'd2);
        chk("btn3_state", {2'b0, dbg_state}, {2'b0, ST_MANUAL});
        tick_frame("hold1", 2'd2);
        tick_frame("hold2", 2'd2);
        tick_frame("hold3", 2'd2);
        chk("hold3_state", {2'b0, dbg_state}, {2'b0, ST_MANUAL});
        tick_frame("hold4", 2'd2);
        chk("hold4_state", {2'b0, dbg_state}, {2'b0, ST_AUTO});

        // MANUAL with auto disabled stays put with hold saturated.
        pulse_btn();
        tick_frame("btn_m3", 2'd3);
        chk("btn_m3_state", {2'b0, dbg_state}, {2'b0, ST_MANUAL});
        auto_en = 1'b0;
        repeat (5) tick_frame("stay", 2'd3);
        chk("stay_state", {2'b0, dbg_state}, {2'b0, ST_MANUAL});
        auto_en = 1'b1;
        tick_frame("reauto", 2'd3);
        chk("reauto_state", {2'b0, dbg_state}, {2'b0, ST_AUTO});

        tick_frame("to_time1", 2'd3);
        tick_frame("to_time2", 2'd3);
        tick_frame("to_time3", 2'd1);
        tick_frame("pre_aud", 2'd1);

        // Audio rise at TIME: jump to WAVEFORM with dwell restarted.
        audio = 1'b1;
        step();
        tick_frame("aud_wake", 2'd2);
        tick_frame("aud_dw1", 2'd2);
        tick_frame("aud_dw2", 2'd2);
        tick_frame("aud_dw3", 2'd3);

        // Audio rise at SPECTRUM is ignored.
        audio = 1'b0;
        step();
        audio = 1'b1;
        step();
        tick_frame("aud_ign", 2'd3);
        tick_frame("aud_ign2", 2'd3);
        tick_frame("aud_ign3", 2'd1);
        audio = 1'b0;

        // Button and audio in the same frame: button wins.
        audio = 1'b1;
        btn   = 1'b1;
        step();
        btn = 1'b0;
        step();
        tick_frame("btn_vs_aud", 2'd2);
        chk("btn_vs_aud_state", {2'b0, dbg_state}, {2'b0, ST_MANUAL});
        audio = 1'b0;
        pulse_btn();
        tick_frame("to_spec", 2'd3);
        chk("to_spec_state", {2'b0, dbg_state}, {2'b0, ST_MANUAL});

        // Asynchronous reset mid-frame.
        vs = 1'b1;
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mode", {2'b0, show_mode}, 4'd0);
        chk("arst_state", {2'b0, dbg_state}, {2'b0, ST_SPLASH});
        chk("arst_chg", {3'b0, mode_changed}, 4'd0);
        chk("arst_tick", {3'b0, frame_tick}, 4'd0);
        step();
        rst      = 1'b0;
        exp_mode = 2'd0;
        tick_frame("resplash1", 2'd0);
        tick_frame("resplash2", 2'd1);
        chk("resplash_state", {2'b0, dbg_state}, {2'b0, ST_AUTO});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
